hs_parallel_output: RTL and testbench



---
 rtl/hs_parallel_pkg.sv | 13 +
 rtl/hs_bus_driver.sv | 37 +++
 rtl/hs_parallel_output.sv | 99 +++++++++
 tb/tb_hs_parallel_output.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_parallel_pkg.sv
// Shared types and constants for the handshaked parallel output port.
package hs_parallel_pkg;

    typedef enum logic [1:0] {
        S_IDLE       = 2'b00,
        S_WAIT_ACK   = 2'b01,
        S_WAIT_READY = 2'b10
    } hs_state_e;

    localparam logic ADDR_BUF = 1'b0;
    localparam logic ADDR_STS = 1'b1;

endpackage

// File: rtl/hs_bus_driver.sv
// Read mux and tri-state driver for the processor data bus.
// Buffer readback at a0=0 is enabled by HS_PAR_OUT_READBACK_EN.
module hs_bus_driver
    import hs_parallel_pkg::*;
#(
    parameter int unsigned FI_BIT = 0
) (
    input  logic       s_,
    input  logic       ior_,
    input  logic       iow_,
    input  logic       a0,
    input  logic [7:0] buf_data,
    input  logic       fi,
    inout  wire  [7:0] d7_d0
);

`ifdef HS_PAR_OUT_READBACK_EN
    localparam logic READBACK = 1'b1;
`else
    localparam logic READBACK = 1'b0;
`endif

    logic       rd_active;
    logic       drive_en;
    logic [7:0] sts_byte;
    logic [7:0] rd_data;

    always_comb begin
        sts_byte  = 8'({7'b0, fi} << FI_BIT);
        rd_active = !s_ && !ior_ && iow_;
        rd_data   = (a0 == ADDR_STS) ? sts_byte : buf_data;
        drive_en  = rd_active && ((a0 == ADDR_STS) || READBACK);
    end

    assign d7_d0 = drive_en ? rd_data : 8'bzzzz_zzzz;

endmodule

// File: rtl/hs_parallel_output.sv
// Handshaked parallel output port: CPU-written buffer, FI status flag and dav_/rfd handshake FSM.
// Optional buffer readback is controlled by HS_PAR_OUT_READBACK_EN (see hs_bus_driver).
//
// state        | meaning
// S_IDLE       | dav_ high; waits for a pending byte (FI=0) and a ready consumer
// S_WAIT_ACK   | dav_ low; byte presented, waits for consumer to drop rfd
// S_WAIT_READY | dav_ high; byte taken, waits for consumer to raise rfd again
module hs_parallel_output
    import hs_parallel_pkg::*;
#(
    parameter int unsigned FI_BIT = 0
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic       s_,
    input  logic       ior_,
    input  logic       iow_,
    input  logic       a0,
    inout  wire  [7:0] d7_d0,
    output logic       dav_,
    input  logic       rfd,
    output logic [7:0] byte_out
);

    hs_state_e  state_q, state_d;
    logic       dav_q, dav_d;
    logic       fi_q, fi_d;
    logic [7:0] buf_q, buf_d;
    logic       wr_buf;

    always_comb begin
        state_d = state_q;
        dav_d   = dav_q;
        fi_d    = fi_q;
        buf_d   = buf_q;
        wr_buf  = !s_ && !iow_ && (a0 == ADDR_BUF) && fi_q;

        if (wr_buf) begin
            buf_d = d7_d0;
            fi_d  = 1'b0;
        end

        // FI is only released in S_WAIT_ACK, where fi_q=0 blocks any write.
        case (state_q)
            S_IDLE: begin
                if (!fi_q && rfd) begin
                    state_d = S_WAIT_ACK;
                    dav_d   = 1'b0;
                end
            end
            S_WAIT_ACK: begin
                if (!rfd) begin
                    state_d = S_WAIT_READY;
                    dav_d   = 1'b1;
                    fi_d    = 1'b1;
                end
            end
            S_WAIT_READY: begin
                if (rfd) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                dav_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q <= S_IDLE;
            dav_q   <= 1'b1;
            fi_q    <= 1'b1;
            buf_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            dav_q   <= dav_d;
            fi_q    <= fi_d;
            buf_q   <= buf_d;
        end
    end

    assign dav_     = dav_q;
    assign byte_out = buf_q;

    hs_bus_driver #(
        .FI_BIT (FI_BIT)
    ) u_bus_driver (
        .s_       (s_),
        .ior_     (ior_),
        .iow_     (iow_),
        .a0       (a0),
        .buf_data (buf_q),
        .fi       (fi_q),
        .d7_d0    (d7_d0)
    );

endmodule

// File: tb/tb_hs_parallel_output.sv
// Directed self-checking bench for hs_parallel_output.
module tb_hs_parallel_output;

    logic       clock = 1'b0;
    logic       reset_;
    logic       s_;
    logic       ior_;
    logic       iow_;
    logic       a0;
    logic       rfd;
    wire  [7:0] d7_d0;
    wire        dav_;
    wire  [7:0] byte_out;

    logic [7:0] tb_d;
    logic       tb_d_en;

    int errors = 0;
    int checks = 0;

    assign d7_d0 = tb_d_en ? tb_d : 8'bzzzz_zzzz;

    always #5 clock = ~clock;

    hs_parallel_output #(.FI_BIT(0)) dut (
        .clock    (clock),
        .reset_   (reset_),
        .s_       (s_),
        .ior_     (ior_),
        .iow_     (iow_),
        .a0       (a0),
        .d7_d0    (d7_d0),
        .dav_     (dav_),
        .rfd      (rfd),
        .byte_out (byte_out)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [7:0] val);
        s_      = 1'b0;
        iow_    = 1'b0;
        ior_    = 1'b1;
        a0      = 1'b0;
        tb_d    = val;
        tb_d_en = 1'b1;
        tick();
        s_      = 1'b1;
        iow_    = 1'b1;
        tb_d_en = 1'b0;
    endtask

    task automatic read_reg(input logic sel, output logic [7:0] val);
        s_      = 1'b0;
        ior_    = 1'b0;
        iow_    = 1'b1;
        a0      = sel;
        tb_d_en = 1'b0;
        #1;
        val     = d7_d0;
        s_      = 1'b1;
        ior_    = 1'b1;
        #1;
    endtask

    // The bench drives a probe pattern; if the DUT also drives, the bus no longer equals the probe.
    task automatic probe_bus(input logic cs, input logic rd, input logic wr, input logic sel,
                             input logic [7:0] pattern, output logic [7:0] val);
        s_      = cs;
        ior_    = rd;
        iow_    = wr;
        a0      = sel;
        tb_d    = pattern;
        tb_d_en = 1'b1;
        #1;
        val     = d7_d0;
        s_      = 1'b1;
        ior_    = 1'b1;
        iow_    = 1'b1;
        tb_d_en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] sts;
        reset_ = 1'b0;
        tick();
        tick();
        reset_ = 1'b1;
        checks++;
        if (dav_ !== 1'b1) begin errors++; $display("FAIL reset_dav: got %b expected 1", dav_); end
        checks++;
        if (byte_out !== 8'h00) begin errors++; $display("FAIL reset_byte_out: got %h expected 00", byte_out); end
        read_reg(1'b1, sts);
        checks++;
        if (sts !== 8'h01) begin errors++; $display("FAIL reset_status: got %h expected 01", sts); end
    endtask

    task automatic test_handshake();
        logic [7:0] sts;
        rfd = 1'b1;
        do_write(8'h41);
        checks++;
        if (byte_out !== 8'h41) begin errors++; $display("FAIL hs_byte_out: got %h expected 41", byte_out); end
        checks++;
        if (dav_ !== 1'b1) begin errors++; $display("FAIL hs_dav_write_edge: got %b expected 1", dav_); end
        tick();
        checks++;
        if (dav_ !== 1'b0) begin errors++; $display("FAIL hs_dav_fall: got %b expected 0", dav_); end
        read_reg(1'b1, sts);
        checks++;
        if (sts !== 8'h00) begin errors++; $display("FAIL hs_status_busy: got %h expected 00", sts); end

        do_write(8'h42);
        checks++;
        if (byte_out !== 8'h41) begin errors++; $display("FAIL hs_write_busy_ignored: got %h expected 41", byte_out); end
        checks++;
        if (dav_ !== 1'b0) begin errors++; $display("FAIL hs_dav_held: got %b expected 0", dav_); end

        rfd = 1'b0;
        tick();
        checks++;
        if (dav_ !== 1'b1) begin errors++; $display("FAIL hs_dav_release: got %b expected 1", dav_); end
        read_reg(1'b1, sts);
        checks++;
        if (sts !== 8'h01) begin errors++; $display("FAIL hs_status_free: got %h expected 01", sts); end
        checks++;
        if (byte_out !== 8'h41) begin errors++; $display("FAIL hs_byte_kept: got %h expected 41", byte_out); end

        rfd = 1'b1;
        tick();
        tick();
        checks++;
        if (dav_ !== 1'b1) begin errors++; $display("FAIL hs_idle_no_pending: got %b expected 1", dav_); end
    endtask

    task automatic test_same_edge();
        logic [7:0] sts;
        rfd = 1'b1;
        do_write(8'h60);
        tick();
        checks++;
        if (dav_ !== 1'b0) begin errors++; $display("FAIL se_dav_fall: got %b expected 0", dav_); end
        rfd = 1'b0;
        do_write(8'h61);
        checks++;
        if (byte_out !== 8'h60) begin errors++; $display("FAIL se_write_ignored: got %h expected 60", byte_out); end
        checks++;
        if (dav_ !== 1'b1) begin errors++; $display("FAIL se_dav_release: got %b expected 1", dav_); end
        read_reg(1'b1, sts);
        checks++;
        if (sts !== 8'h01) begin errors++; $display("FAIL se_status: got %h expected 01", sts); end
        rfd = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] sts;
        rfd = 1'b1;
        do_write(8'h50);
        tick();
        rfd = 1'b0;
        tick();
        do_write(8'h51);
        checks++;
        if (byte_out !== 8'h51) begin errors++; $display("FAIL b2b_byte_out: got %h expected 51", byte_out); end
        read_reg(1'b1, sts);
        checks++;
        if (sts !== 8'h00) begin errors++; $display("FAIL b2b_status: got %h expected 00", sts); end
        tick();
        checks++;
        if (dav_ !== 1'b1) begin errors++; $display("FAIL b2b_dav_wait_ready: got %b expected 1", dav_); end
        rfd = 1'b1;
        tick();
        checks++;
        if (dav_ !== 1'b1) begin errors++; $display("FAIL b2b_dav_to_idle: got %b expected 1", dav_); end
        tick();
        checks++;
        if (dav_ !== 1'b0) begin errors++; $display("FAIL b2b_dav_fall: got %b expected 0", dav_); end
        rfd = 1'b0;
        tick();
        checks++;
        if (dav_ !== 1'b1) begin errors++; $display("FAIL b2b_dav_release: got %b expected 1", dav_); end
        rfd = 1'b1;
        tick();
    endtask

    task automatic test_bus();
        logic [7:0] v;
        probe_bus(1'b1, 1'b0, 1'b1, 1'b1, 8'hA4, v);
        checks++;
        if (v !== 8'hA4) begin errors++; $display("FAIL bus_idle_cs: got %h expected A4", v); end
        probe_bus(1'b0, 1'b0, 1'b0, 1'b1, 8'hA4, v);
        checks++;
        if (v !== 8'hA4) begin errors++; $display("FAIL bus_rd_wr_both: got %h expected A4", v); end
`ifdef HS_PAR_OUT_READBACK_EN
        read_reg(1'b0, v);
        checks++;
        if (v !== 8'h51) begin errors++; $display("FAIL bus_readback: got %h expected 51", v); end
`else
        probe_bus(1'b0, 1'b0, 1'b1, 1'b0, 8'h82, v);
        checks++;
        if (v !== 8'h82) begin errors++; $display("FAIL bus_no_readback: got %h expected 82", v); end
`endif
        s_      = 1'b0;
        iow_    = 1'b0;
        a0      = 1'b1;
        tb_d    = 8'h99;
        tb_d_en = 1'b1;
        tick();
        s_      = 1'b1;
        iow_    = 1'b1;
        tb_d_en = 1'b0;
        checks++;
        if (byte_out !== 8'h51) begin errors++; $display("FAIL bus_status_write_ignored: got %h expected 51", byte_out); end
        read_reg(1'b1, v);
        checks++;
        if (v !== 8'h01) begin errors++; $display("FAIL bus_status_after_sts_write: got %h expected 01", v); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] sts;
        rfd = 1'b1;
        do_write(8'h70);
        tick();
        checks++;
        if (dav_ !== 1'b0) begin errors++; $display("FAIL rm_dav_fall: got %b expected 0", dav_); end
        reset_ = 1'b0;
        tick();
        reset_ = 1'b1;
        checks++;
        if (dav_ !== 1'b1) begin errors++; $display("FAIL rm_dav: got %b expected 1", dav_); end
        checks++;
        if (byte_out !== 8'h00) begin errors++; $display("FAIL rm_byte_out: got %h expected 00", byte_out); end
        read_reg(1'b1, sts);
        checks++;
        if (sts !== 8'h01) begin errors++; $display("FAIL rm_status: got %h expected 01", sts); end
        do_write(8'h71);
        checks++;
        if (byte_out !== 8'h71) begin errors++; $display("FAIL rm_rewrite: got %h expected 71", byte_out); end
        tick();
        checks++;
        if (dav_ !== 1'b0) begin errors++; $display("FAIL rm_dav_after_rewrite: got %b expected 0", dav_); end
        rfd = 1'b0;
        tick();
        checks++;
        if (dav_ !== 1'b1) begin errors++; $display("FAIL rm_dav_release: got %b expected 1", dav_); end
        rfd = 1'b1;
        tick();
    endtask

    initial begin
        reset_  = 1'b0;
        s_      = 1'b1;
        ior_    = 1'b1;
        iow_    = 1'b1;
        a0      = 1'b0;
        rfd     = 1'b1;
        tb_d    = 8'h00;
        tb_d_en = 1'b0;
        test_reset();
        test_handshake();
        test_same_edge();
        test_back_to_back();
        test_bus();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
